// File: rtl/branch_stack_if.sv
// branch_stack_if: dispatch allocation, branch resolution and recovery broadcast
// signals shared between the pipeline and the branch mask manager.
interface branch_stack_if #(parameter int NUM_BRANCHES = 4);
    typedef struct packed {
        logic                    valid;
        logic [NUM_BRANCHES-1:0] bmm;
        logic                    bm_mispred;
        logic                    actual_taken;
        logic [31:0]             target_PC;
    } branch_reg_packet_t;
    logic                    alloc_req;
    logic [31:0]             alloc_NPC;
    logic                    alloc_grant;
    logic [NUM_BRANCHES-1:0] alloc_bmm;
    logic [NUM_BRANCHES-1:0] active_mask;
    logic                    full;
    branch_reg_packet_t      branch_reg_result;
    logic                    resolve_valid;
    logic [NUM_BRANCHES-1:0] resolve_bmm;
    logic                    squash;
    logic [NUM_BRANCHES-1:0] squash_mask;
    logic [31:0]             redirect_PC;
    modport master (
        output alloc_req, alloc_NPC, branch_reg_result,
        input  alloc_grant, alloc_bmm, active_mask, full,
               resolve_valid, resolve_bmm, squash, squash_mask, redirect_PC
    );
    modport slave (
        input  alloc_req, alloc_NPC, branch_reg_result,
        output alloc_grant, alloc_bmm, active_mask, full,
               resolve_valid, resolve_bmm, squash, squash_mask, redirect_PC
    );
endinterface

// File: rtl/branch_stack.sv
// branch_stack: one-hot branch mask allocator with per-slot fall-through NPC and
// older-branch tracking; frees slots on correct resolution, squashes on mispredict.
module branch_stack #(parameter int NUM_BRANCHES = 4) (
    input logic           clock,
    input logic           reset,
    branch_stack_if.slave bs
);
    localparam int N = NUM_BRANCHES;
    typedef enum logic {NORMAL, RECOVER} state_t;
    state_t         state;
    logic [N-1:0]   valid_q;
    logic [31:0]    npc [N];
    logic [N-1:0]   older [N];
    logic           hit, cor, mis;
    logic [N-1:0]   bmm, free, younger, sq_mask, clr;
    logic [31:0]    slot_npc;
    assign bmm  = bs.branch_reg_result.bmm;
    assign hit  = bs.branch_reg_result.valid && |(bmm & valid_q);
    assign cor  = hit && !bs.branch_reg_result.bm_mispred;
    assign mis  = hit && bs.branch_reg_result.bm_mispred;
    assign clr  = cor ? bmm : '0;
    assign free = ~valid_q;
    assign bs.alloc_grant = bs.alloc_req && state == NORMAL && !mis && |free;
    assign bs.alloc_bmm   = bs.alloc_grant ? free & (~free + N'(1)) : '0;
    assign bs.full        = &valid_q || state == RECOVER;
    assign bs.active_mask = valid_q;
    // Only live slots count as younger; squashed slots may hold stale older masks.
    always_comb begin
        younger  = '0;
        slot_npc = '0;
        for (int i = 0; i < N; i++) begin
            younger[i] = valid_q[i] && |(older[i] & bmm);
            slot_npc   = slot_npc | (bmm[i] ? npc[i] : '0);
        end
    end
    assign sq_mask = bmm | younger;
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= NORMAL;
            valid_q          <= '0;
            bs.resolve_valid <= 1'b0;
            bs.resolve_bmm   <= '0;
            bs.squash        <= 1'b0;
            bs.squash_mask   <= '0;
            bs.redirect_PC   <= '0;
            for (int i = 0; i < N; i++) begin
                npc[i]   <= '0;
                older[i] <= '0;
            end
        end else begin
            state   <= (state == NORMAL && mis) ? RECOVER : NORMAL;
            valid_q <= (valid_q & ~clr & ~(mis ? sq_mask : '0)) | bs.alloc_bmm;
            for (int i = 0; i < N; i++) begin
                older[i] <= bs.alloc_bmm[i] ? valid_q & ~clr : older[i] & ~clr;
                if (bs.alloc_bmm[i]) npc[i] <= bs.alloc_NPC;
            end
            bs.resolve_valid <= hit;
            bs.resolve_bmm   <= hit ? bmm : '0;
            bs.squash        <= mis;
            bs.squash_mask   <= mis ? sq_mask : '0;
            bs.redirect_PC   <= mis ? (bs.branch_reg_result.actual_taken ?
                                       bs.branch_reg_result.target_PC : slot_npc) : '0;
        end
    end
endmodule

// File: tb/tb_branch_stack.sv
// tb_branch_stack: directed plus random stimulus against an age-ordered reference model;
// resolution responses are queued by the driver and checked by a separate monitor.
module tb_branch_stack;
    typedef struct {
        logic [3:0]  bmm;
        logic        sq;
        logic [3:0]  mask;
        logic [31:0] pc;
    } exp_t;
    logic clock, reset;
    int   vectors = 0, miscompares = 0;
    bit   started = 0;
    exp_t expq [$];
    bit          pend [4];
    logic [31:0] mnpc [4];
    int          mseq [4];
    bit          mrec;
    int          ctr;
    branch_stack_if #(.NUM_BRANCHES(4)) bif ();
    branch_stack #(.NUM_BRANCHES(4)) dut (.clock(clock), .reset(reset), .bs(bif));
    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic cycle(input bit rq, input logic [31:0] anpc, input bit pv, input logic [3:0] pb,
                         input bit pm, input bit pt, input logic [31:0] tgt, input bit rs);
        logic [3:0] pvec, gb, sm;
        bit hit, g;
        int b, gi;
        exp_t e;
        @(negedge clock);
        reset = rs;
        bif.alloc_req = rq;
        bif.alloc_NPC = anpc;
        bif.branch_reg_result.valid = pv;
        bif.branch_reg_result.bmm = pb;
        bif.branch_reg_result.bm_mispred = pm;
        bif.branch_reg_result.actual_taken = pt;
        bif.branch_reg_result.target_PC = tgt;
        #1;
        pvec = '0;
        b = 0;
        for (int i = 0; i < 4; i++) begin
            pvec[i] = pend[i];
            if (pb[i]) b = i;
        end
        hit = pv && (pb & pvec) != 0;
        g = rq && !mrec && !(hit && pm) && pvec != 4'hf;
        gb = '0;
        gi = 0;
        for (int i = 3; i >= 0; i--)
            if (g && !pend[i]) begin
                gb = 4'(1 << i);
                gi = i;
            end
        if (!rs && started) begin
            check("alloc_grant", 32'(bif.alloc_grant), 32'(g));
            check("alloc_bmm", 32'(bif.alloc_bmm), 32'(gb));
            check("full", 32'(bif.full), 32'(mrec || pvec == 4'hf));
            check("active_mask", 32'(bif.active_mask), 32'(pvec));
        end
        if (rs) begin
            for (int i = 0; i < 4; i++) pend[i] = 0;
            mrec = 0;
            started = 1;
        end else begin
            if (hit) begin
                sm = pb;
                for (int j = 0; j < 4; j++) if (pend[j] && mseq[j] > mseq[b]) sm[j] = 1;
                e.bmm = pb;
                e.sq = pm;
                e.mask = pm ? sm : 4'h0;
                e.pc = pm ? (pt ? tgt : mnpc[b]) : 32'h0;
                expq.push_back(e);
                if (pm) for (int j = 0; j < 4; j++) begin if (sm[j]) pend[j] = 0; end
                else pend[b] = 0;
            end
            mrec = !mrec && hit && pm;
            if (g) begin
                pend[gi] = 1;
                mnpc[gi] = anpc;
                mseq[gi] = ++ctr;
            end
        end
    endtask
    task automatic idle(input bit rq, input logic [31:0] anpc);
        cycle(rq, anpc, 0, 4'h0, 0, 0, 32'h0, 0);
    endtask
    task automatic res(input logic [3:0] pb, input bit pm, input bit pt, input logic [31:0] tgt);
        cycle(0, 32'h0, 1, pb, pm, pt, tgt, 0);
    endtask
    task automatic rst_cycle();
        cycle(0, 32'h0, 0, 4'h0, 0, 0, 32'h0, 1);
    endtask
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (started) begin
                if (bif.resolve_valid) begin
                    if (expq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_resolve: got bmm %h expected none", bif.resolve_bmm);
                    end else begin
                        e = expq.pop_front();
                        check("resolve_bmm", 32'(bif.resolve_bmm), 32'(e.bmm));
                        check("squash", 32'(bif.squash), 32'(e.sq));
                        check("squash_mask", 32'(bif.squash_mask), 32'(e.mask));
                        check("redirect_PC", bif.redirect_PC, e.pc);
                    end
                end else
                    check("idle_outputs", {26'(bif.resolve_bmm), bif.squash, bif.squash_mask, 1'b0},
                          32'h0);
            end
        end
    end
    initial begin
        reset = 0;
        bif.alloc_req = 0;
        bif.alloc_NPC = 0;
        bif.branch_reg_result = '0;
        ctr = 0;
        mrec = 0;
        rst_cycle();
        for (int i = 0; i < 5; i++) idle(1, 32'h104 + 32'(i) * 32'h100);
        res(4'b0010, 0, 0, 32'h0);
        idle(1, 32'h504);
        rst_cycle();
        for (int i = 0; i < 4; i++) idle(1, 32'h104 + 32'(i) * 32'h100);
        res(4'b0010, 1, 0, 32'h0);
        idle(1, 32'h904);
        idle(1, 32'h904);
        rst_cycle();
        for (int i = 0; i < 3; i++) idle(1, 32'h104 + 32'(i) * 32'h100);
        res(4'b0001, 1, 1, 32'h8000);
        idle(0, 32'h0);
        rst_cycle();
        idle(1, 32'h104);
        cycle(1, 32'h204, 1, 4'b0001, 0, 0, 32'h0, 0);
        res(4'b0010, 1, 0, 32'h0);
        idle(0, 32'h0);
        res(4'b0100, 0, 0, 32'h0);
        idle(1, 32'h304);
        res(4'b0001, 1, 1, 32'h1234);
        rst_cycle();
        idle(0, 32'h0);
        for (int n = 0; n < 3000; n++)
            cycle($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 4,
                  4'(1 << $urandom_range(0, 3)), $urandom_range(0, 3) == 0, 1'($urandom),
                  $urandom, $urandom_range(0, 99) == 0);
        idle(0, 32'h0);
        idle(0, 32'h0);
        check("queue_drained", 32'(expq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/branch_stack.md
# branch_stack

Branch-mask manager sitting directly downstream of the branch execution unit and alongside dispatch. At dispatch it allocates a one-hot branch mask slot for every branch and records that branch's fall-through NPC plus the set of older branches still in flight. It consumes the branch unit's resolution packet. On a correct prediction it frees the slot; on a misprediction it squashes the branch and all younger branches and broadcasts a registered redirect PC and squash mask to the rest of the pipeline.

## Interface
Parameters:
- NUM_BRANCHES, 4, number of checkpoint slots; also the branch mask width N.

Ports:
- clock  in  1  core clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- alloc_req  in  1  dispatch requests a slot for one branch this cycle.
- alloc_NPC  in  32  fall-through PC of the dispatching branch.
- alloc_grant  out  1  combinational; request accepted this cycle.
- alloc_bmm  out  N  combinational one-hot slot granted; 0 when alloc_grant=0.
- active_mask  out  N  registered; slots currently PENDING. Dispatch ORs this into each instruction's dependency mask.
- full  out  1  combinational; no FREE slot, or state is RECOVER.
- branch_reg_result  in  BRANCH_REG_PACKET  from branch unit. Uses fields valid, bmm (one-hot), bm_mispred, actual_taken, target_PC.
- resolve_valid  out  1  registered; a resolution was processed last cycle.
- resolve_bmm  out  N  registered; slot resolved. Consumers clear this bit from their masks when squash=0.
- squash  out  1  registered; misprediction recovery this cycle.
- squash_mask  out  N  registered; resolved slot plus all younger slots. Consumers kill any entry whose mask intersects it.
- redirect_PC  out  32  registered; fetch target when squash=1.

## Operation
- Per-slot state: valid bit, NPC[31:0], older[N-1:0] (slots PENDING when this slot was allocated).
- Global FSM: NORMAL, RECOVER.
  - NORMAL -> RECOVER on an accepted mispredict.
  - RECOVER -> NORMAL unconditionally after one cycle.
  - No allocation is granted in RECOVER.
- Allocation: grant the lowest-index FREE slot when alloc_req=1, state=NORMAL and no mispredict resolves this cycle.
  - On grant: valid<=1, NPC<=alloc_NPC, older<=active_mask with the bit of any slot correctly resolving this same cycle cleared.
- Resolution is accepted when branch_reg_result.valid=1 and its bmm hits a valid slot. A resolution whose bmm misses every valid slot is ignored: no outputs assert.
  - Correct (bm_mispred=0):
    - Clear the slot's valid bit.
    - Clear that bit from every slot's older mask.
    - Next cycle: resolve_valid=1, resolve_bmm=bmm, squash=0.
  - Mispredict (bm_mispred=1):
    - squash_mask = bmm | every slot j with older[j] & bmm.
    - Clear valid for all slots in squash_mask.
    - redirect_PC = actual_taken ? target_PC : slot NPC.
    - Next cycle: resolve_valid=1, squash=1, with resolve_bmm, squash_mask and redirect_PC as computed.
- A slot freed this cycle is not re-granted until the next cycle.
- When no resolution is accepted, resolve_valid, squash, resolve_bmm, squash_mask and redirect_PC are all 0 next cycle.

## Timing
- Reset: all slots FREE, older=0, NPC=0, FSM=NORMAL.
  - Registered outputs after reset: active_mask=0, resolve_valid=0, squash=0, resolve_bmm=0, squash_mask=0, redirect_PC=0.
  - Combinational outputs after reset: full=0; alloc_grant and alloc_bmm follow alloc_req.
- Reset has priority over all inputs. Reset asserted during RECOVER returns to NORMAL with everything cleared.
- Allocation: grant is combinational in cycle t. The slot appears in active_mask at t+1.
- Resolution: packet at t -> outputs valid for exactly one cycle at t+1. State is updated at the same edge.
- Mispredict at t: alloc_grant=0 at t; RECOVER during t+1; allocation is possible again at t+2.
- Full: with all N slots PENDING, full=1 and alloc_grant=0. A correct resolution at t makes the slot grantable at t+1.
- One resolution per cycle. Alloc plus correct resolve in the same cycle: both are honoured.

## Test plan
- Reset, then alloc_req for 4 cycles with NPCs 0x104/0x204/0x304/0x404 -> alloc_bmm 0001, 0010, 0100, 1000; active_mask=1111; full=1. A 5th request gives alloc_grant=0.
- Correct resolve of bmm=0010 -> next cycle resolve_valid=1, resolve_bmm=0010, squash=0; active_mask=1101. The next alloc_req gets 0010.
- 4 slots allocated in order, mispredict on bmm=0010 with actual_taken=0 -> next cycle squash=1, squash_mask=1110, redirect_PC=0x204; active_mask=0001. alloc_grant=0 during RECOVER, then 1 and returns 0010.
- Mispredict with actual_taken=1, target_PC=0x8000 on oldest slot 0001 -> squash_mask=all allocated slots, redirect_PC=0x8000.
- Same cycle: alloc_req plus correct resolve of 0001 with only 0001 PENDING -> grant 0010, and that slot's older=0000. A later mispredict of 0010 gives squash_mask=0010 only.
- Resolution with valid=1 and bmm=0100 where slot 2 is FREE -> no output change; resolve_valid stays 0. Reset asserted one cycle after a mispredict -> all outputs 0 next cycle.
